// File: rtl/gauss_sample_collector_if.sv
// Sample and read-bus bundle between the Gaussian generator, the collector
// and the processor.
//
// Handshake semantics (one place, applies to every signal below):
//   Sample side: there is no back-pressure. A sample is offered on any cycle
//   with smp_valid_in=1. The collector consumes it on that edge, or drops it
//   and records the loss. gen_enable_out is a level that asks the generator
//   to keep producing.
//   Read side: rd_req is a one-cycle strobe. It is honoured only when the FIFO
//   is non-empty. rd_valid pulses exactly one cycle after an honoured strobe,
//   and rd_data is meaningful in that cycle.
//
// Modports:
//   master - generator/processor side (drives samples and read strobes)
//   slave  - collector side
interface gauss_sample_collector_if #(
  parameter int DATA_W = 32
);
  logic              smp_valid_in;
  logic [DATA_W-1:0] smp_data_in;
  logic              smp_invalid_in;
  logic              gen_complete_in;
  logic              gen_enable_out;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output smp_valid_in, smp_data_in, smp_invalid_in, gen_complete_in, rd_req,
    input  gen_enable_out, rd_data, rd_valid
  );

  modport slave (
    input  smp_valid_in, smp_data_in, smp_invalid_in, gen_complete_in, rd_req,
    output gen_enable_out, rd_data, rd_valid
  );
endinterface

// File: rtl/gauss_sample_collector.sv
// gauss_sample_collector
// Consumer end of the Gaussian RNG sample stream. Good samples are pushed
// into a FIFO for the processor, accepted/rejected samples are counted, and
// accepted samples are summed. A run ends after TARGET_CNT accepts or when the
// generator reports completion, then the FIFO is drained.
//
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   start        one-cycle pulse: begin a run (honoured in IDLE/DONE only)
//   bus          sample + read bus (slave modport)
//   fifo_empty   FIFO holds 0 entries (registered, exact)
//   fifo_full    FIFO holds FIFO_DEPTH entries (registered, exact)
//   accept_cnt   accepted samples this run
//   reject_cnt   rejected samples this run, saturating
//   sum_out      signed wrapping 48-bit sum of accepted samples
//   overflow     sticky: a good sample was dropped on a full FIFO
//   done         1 while in DONE
//   state_out    IDLE=0, COLLECT=1, DRAIN=2, DONE=3
module gauss_sample_collector #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int TARGET_CNT = 10000000,
  parameter int CNT_W      = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  gauss_sample_collector_if.slave      bus,
  output logic                         fifo_empty,
  output logic                         fifo_full,
  output logic [CNT_W-1:0]             accept_cnt,
  output logic [CNT_W-1:0]             reject_cnt,
  output logic [47:0]                  sum_out,
  output logic                         overflow,
  output logic                         done,
  output logic [1:0]                   state_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] TARGET = CNT_W'(TARGET_CNT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              below_target, sampling, good, bad, push, pop, restart;
  logic [47:0]       sample_ext;

  always_comb begin
    below_target = accept_cnt < TARGET;
    // Once the target accept has landed, the FSM still sits in COLLECT for
    // one cycle; gating on below_target keeps accept_cnt from overshooting.
    sampling     = (state == S_COLLECT) && below_target;
    good         = sampling && bus.smp_valid_in && !bus.smp_invalid_in;
    bad          = sampling && bus.smp_valid_in && bus.smp_invalid_in;
    pop          = bus.rd_req && !fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push         = good && (!fifo_full || pop);
    restart      = start && ((state == S_IDLE) || (state == S_DONE));
    wr_ptr_nxt   = wr_ptr + {{AW{1'b0}}, push};
    rd_ptr_nxt   = rd_ptr + {{AW{1'b0}}, pop};
    sample_ext   = {{(48-DATA_W){bus.smp_data_in[DATA_W-1]}}, bus.smp_data_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start) state <= S_COLLECT;
        S_COLLECT: if ((accept_cnt == TARGET) || bus.gen_complete_in) state <= S_DRAIN;
        // Wait for the last popped word to be presented before finishing.
        S_DRAIN:   if (fifo_empty && !rd_valid_q) state <= S_DONE;
        S_DONE:    if (start) state <= S_COLLECT;
        default:   state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accept_cnt <= '0;
      reject_cnt <= '0;
      sum_out    <= '0;
      overflow   <= 1'b0;
    end else if (restart) begin
      accept_cnt <= '0;
      reject_cnt <= '0;
      sum_out    <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        accept_cnt <= accept_cnt + CNT_W'(1);
        sum_out    <= sum_out + sample_ext;
      end
      if (bad && (reject_cnt != '1)) reject_cnt <= reject_cnt + CNT_W'(1);
      if (good && !push) overflow <= 1'b1;
    end
  end

  // Flags are computed from next-pointer values so they are exact on the
  // same edge that moves the pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      fifo_empty <= (wr_ptr_nxt == rd_ptr_nxt);
      fifo_full  <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                    (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
      rd_valid_q <= pop;
      if (pop) rd_data_q <= mem[rd_ptr[AW-1:0]];
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.smp_data_in;
  end

  assign bus.gen_enable_out = sampling;
  assign bus.rd_data        = rd_data_q;
  assign bus.rd_valid       = rd_valid_q;
  assign done               = (state == S_DONE);
  assign state_out          = state;

endmodule

// File: tb/tb_gauss_sample_collector.sv
module tb_gauss_sample_collector;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int TARGET = 8;
  localparam int CNT_W  = 24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  gauss_sample_collector_if #(.DATA_W(DATA_W)) bus ();

  logic              fifo_empty, fifo_full, overflow, done;
  logic [CNT_W-1:0]  accept_cnt, reject_cnt;
  logic [47:0]       sum_out;
  logic [1:0]        state_out;

  gauss_sample_collector #(
    .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .TARGET_CNT(TARGET), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .accept_cnt(accept_cnt), .reject_cnt(reject_cnt), .sum_out(sum_out),
    .overflow(overflow), .done(done), .state_out(state_out)
  );

  // ---------------- scoreboard / counters ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Phase numbers follow the documented state_out encoding.
  int                m_phase;
  logic [DATA_W-1:0] exp_q[$];
  int                m_acc, m_rej;
  logic [47:0]       m_sum;
  bit                m_ovf, m_rd_valid;
  logic [DATA_W-1:0] m_rd_data;

  task automatic model_reset();
    m_phase = 0; exp_q.delete(); m_acc = 0; m_rej = 0; m_sum = '0;
    m_ovf = 0; m_rd_valid = 0; m_rd_data = '0;
  endtask

  task automatic model_step();
    int nxt, sz;
    bit pop, qual, good, bad, push;
    sz   = exp_q.size();
    pop  = bus.rd_req && (sz > 0);
    qual = (m_phase == 1) && (m_acc < TARGET);
    good = qual && bus.smp_valid_in && !bus.smp_invalid_in;
    bad  = qual && bus.smp_valid_in && bus.smp_invalid_in;
    push = good && ((sz < DEPTH) || pop);
    nxt  = m_phase;
    case (m_phase)
      0, 3: if (start) nxt = 1;
      1:    if ((m_acc == TARGET) || bus.gen_complete_in) nxt = 2;
      2:    if ((sz == 0) && !m_rd_valid) nxt = 3;
      default: nxt = 0;
    endcase
    if (start && (m_phase == 0 || m_phase == 3)) begin
      m_acc = 0; m_rej = 0; m_sum = '0; m_ovf = 0;
    end else begin
      if (push) begin
        m_acc++;
        m_sum = m_sum + {{(48-DATA_W){bus.smp_data_in[DATA_W-1]}}, bus.smp_data_in};
      end
      if (bad && m_rej < (1 << CNT_W) - 1) m_rej++;
      if (good && !push) m_ovf = 1;
    end
    if (pop) begin
      m_rd_data  = exp_q.pop_front();
      m_rd_valid = 1;
    end else begin
      m_rd_valid = 0;
    end
    if (push) exp_q.push_back(bus.smp_data_in);
    m_phase = nxt;
  endtask

  task automatic compare_all();
    chk("state_out",  64'(state_out),  64'(m_phase));
    chk("fifo_empty", 64'(fifo_empty), 64'(exp_q.size() == 0));
    chk("fifo_full",  64'(fifo_full),  64'(exp_q.size() == DEPTH));
    chk("accept_cnt", 64'(accept_cnt), 64'(m_acc));
    chk("reject_cnt", 64'(reject_cnt), 64'(m_rej));
    chk("sum_out",    64'(sum_out),    64'(m_sum));
    chk("overflow",   64'(overflow),   64'(m_ovf));
    chk("done",       64'(done),       64'(m_phase == 3));
    chk("gen_enable", 64'(bus.gen_enable_out), 64'((m_phase == 1) && (m_acc < TARGET)));
    chk("rd_valid",   64'(bus.rd_valid), 64'(m_rd_valid));
    chk("rd_data",    64'(bus.rd_data),  64'(m_rd_data));
  endtask

  initial model_reset();
  always @(posedge reset) model_reset();

  always @(posedge clk) begin
    if (reset) model_reset();
    else model_step();
    #1;
    compare_all();
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; inputs are held through the next rising edge.
  task automatic tick(input bit v, input logic [31:0] d, input bit inv,
                      input bit rd, input bit st, input bit gc);
    bus.smp_valid_in    = v;
    bus.smp_data_in     = d;
    bus.smp_invalid_in  = inv;
    bus.rd_req          = rd;
    start               = st;
    bus.gen_complete_in = gc;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 32'h0, 0, 0, 0, 0);
  endtask

  task automatic good(input logic [31:0] d);
    tick(1, d, 0, 0, 0, 0);
  endtask

  task automatic rd_check(input string name, input logic [31:0] exp);
    tick(0, 32'h0, 0, 1, 0, 0);
    chk({name, "_valid"}, 64'(bus.rd_valid), 64'(1));
    chk(name, 64'(bus.rd_data), 64'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.smp_valid_in = 0; bus.smp_data_in = '0; bus.smp_invalid_in = 0;
    bus.rd_req = 0; bus.gen_complete_in = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2);
    chk("reset_state", 64'(state_out), 64'(0));
    chk("reset_empty", 64'(fifo_empty), 64'(1));

    // accept/reject mix, then reads, then reach target
    tick(0, 32'h0, 0, 0, 1, 0);
    chk("start_state", 64'(state_out), 64'(1));
    good(32'h0000_8000);
    tick(1, 32'h0000_1234, 1, 0, 0, 0);
    good(32'hFFFF_8000);
    good(32'h0000_4000);
    good(32'h0000_2000);
    chk("t2_rej", 64'(reject_cnt), 64'(1));
    chk("t2_acc", 64'(accept_cnt), 64'(4));
    chk("t2_sum", 64'(sum_out), 64'h6000);
    chk("t2_full", 64'(fifo_full), 64'(1));
    rd_check("t3_rd0", 32'h0000_8000);
    rd_check("t3_rd1", 32'hFFFF_8000);
    rd_check("t3_rd2", 32'h0000_4000);
    rd_check("t3_rd3", 32'h0000_2000);
    good(32'h10); good(32'h20); good(32'h30); good(32'h40);
    chk("tgt_acc", 64'(accept_cnt), 64'(8));
    chk("tgt_gen_en", 64'(bus.gen_enable_out), 64'(0));
    good(32'h999);
    chk("tgt_ignored_acc", 64'(accept_cnt), 64'(8));
    chk("tgt_sum", 64'(sum_out), 64'h60A0);
    chk("tgt_drain", 64'(state_out), 64'(2));
    tick(0, 32'h0, 0, 0, 1, 0);
    chk("drain_start_ignored", 64'(state_out), 64'(2));
    rd_check("dr_rd0", 32'h10);
    rd_check("dr_rd1", 32'h20);
    rd_check("dr_rd2", 32'h30);
    rd_check("dr_rd3", 32'h40);
    idle(3);
    chk("t3_done_state", 64'(state_out), 64'(3));
    chk("t3_done", 64'(done), 64'(1));

    // overflow run, restarted from DONE
    tick(0, 32'h0, 0, 0, 1, 0);
    chk("t6_state", 64'(state_out), 64'(1));
    chk("t6_acc_clr", 64'(accept_cnt), 64'(0));
    chk("t6_sum_clr", 64'(sum_out), 64'(0));
    for (int i = 1; i <= 6; i++) good(32'(i));
    chk("t4_full", 64'(fifo_full), 64'(1));
    chk("t4_acc", 64'(accept_cnt), 64'(4));
    chk("t4_ovf", 64'(overflow), 64'(1));
    tick(1, 32'h7, 0, 1, 0, 0);
    chk("t4_acc_pp", 64'(accept_cnt), 64'(5));
    chk("t4_full_pp", 64'(fifo_full), 64'(1));
    chk("t4_rd_pp", 64'(bus.rd_data), 64'(1));
    tick(0, 32'h0, 0, 0, 0, 1);
    chk("t6_gc_drain", 64'(state_out), 64'(2));
    for (int i = 0; i < 4; i++) tick(0, 32'h0, 0, 1, 0, 0);
    idle(3);
    chk("t6_done", 64'(state_out), 64'(3));

    // empty-edge push+read, then asynchronous reset mid-run
    tick(0, 32'h0, 0, 0, 1, 0);
    chk("t6_ovf_clr", 64'(overflow), 64'(0));
    tick(1, 32'h55, 0, 1, 0, 0);
    chk("t5_no_valid", 64'(bus.rd_valid), 64'(0));
    chk("t5_not_empty", 64'(fifo_empty), 64'(0));
    good(32'h56); good(32'h57); good(32'h58);
    chk("t1_pre_full", 64'(fifo_full), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("t1_state", 64'(state_out), 64'(0));
    chk("t1_empty", 64'(fifo_empty), 64'(1));
    chk("t1_acc", 64'(accept_cnt), 64'(0));
    chk("t1_gen_en", 64'(bus.gen_enable_out), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(1);

    // randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      logic [31:0] d;
      d = 32'($urandom_range(0, 65535));
      if ($urandom_range(0, 1) == 1) d = -d;
      if ($urandom_range(0, 19) == 0) d = $urandom;
      tick($urandom_range(0, 99) < 60, d, $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 4,
           $urandom_range(0, 199) == 0);
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
